// File: rtl/hba_reg_bank.sv
// rtl/hba_reg_bank.sv - HBA bus slave front end with stored R/W and external read-only registers
// One ack per select assertion; the DESEL state holds off re-acceptance until select drops.
module hba_reg_bank #(
  parameter int DBUS_WIDTH        = 8,
  parameter int PERIPH_ADDR_WIDTH = 4,
  parameter int REG_ADDR_WIDTH    = 8,
  parameter int ADDR_WIDTH        = PERIPH_ADDR_WIDTH + REG_ADDR_WIDTH,
  parameter int PERIPH_ADDR       = 0,
  parameter int NUM_WR_REGS       = 4,
  parameter int NUM_RD_REGS       = 2
) (
  input  logic                              hba_clk,
  input  logic                              hba_reset,
  input  logic                              hba_select,
  input  logic                              hba_rnw,
  input  logic [ADDR_WIDTH-1:0]             hba_abus,
  input  logic [DBUS_WIDTH-1:0]             hba_dbus,
  output logic                              slave_xferack,
  output logic [DBUS_WIDTH-1:0]             slave_dbus,
  output logic [NUM_WR_REGS*DBUS_WIDTH-1:0] reg_out,
  input  logic [NUM_RD_REGS*DBUS_WIDTH-1:0] reg_in,
  output logic                              reg_wr_strobe,
  output logic                              reg_rd_strobe,
  output logic [REG_ADDR_WIDTH-1:0]         reg_index
);

  localparam int NUM_REGS = NUM_WR_REGS + NUM_RD_REGS;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACK   = 2'd1,
    ST_DESEL = 2'd2
  } state_t;

  state_t                    r_state;
  logic [DBUS_WIDTH-1:0]     r_regs [NUM_WR_REGS];
  logic                      r_xferack;
  logic [DBUS_WIDTH-1:0]     r_dbus;
  logic                      r_wr_strobe;
  logic                      r_rd_strobe;
  logic [REG_ADDR_WIDTH-1:0] r_index;

  logic                      w_hit;
  logic [REG_ADDR_WIDTH-1:0] w_index;
  logic                      w_in_wr_range;
  logic                      w_in_any_range;
  logic [DBUS_WIDTH-1:0]     w_rd_data;

  assign w_index        = hba_abus[REG_ADDR_WIDTH-1:0];
  assign w_hit          = hba_select &&
                          (hba_abus[ADDR_WIDTH-1:REG_ADDR_WIDTH] == PERIPH_ADDR_WIDTH'(PERIPH_ADDR));
  assign w_in_wr_range  = ({1'b0, w_index} < (REG_ADDR_WIDTH+1)'(NUM_WR_REGS));
  assign w_in_any_range = ({1'b0, w_index} < (REG_ADDR_WIDTH+1)'(NUM_REGS));

  // Out-of-range indices fall through to zero read data.
  always_comb begin
    w_rd_data = '0;
    for (int i = 0; i < NUM_WR_REGS; i++) begin
      if (w_index == REG_ADDR_WIDTH'(i)) w_rd_data = r_regs[i];
    end
    for (int j = 0; j < NUM_RD_REGS; j++) begin
      if (w_index == REG_ADDR_WIDTH'(NUM_WR_REGS + j)) w_rd_data = reg_in[j*DBUS_WIDTH +: DBUS_WIDTH];
    end
  end

  always_ff @(posedge hba_clk or posedge hba_reset) begin
    if (hba_reset) begin
      r_state     <= ST_IDLE;
      r_xferack   <= 1'b0;
      r_dbus      <= '0;
      r_wr_strobe <= 1'b0;
      r_rd_strobe <= 1'b0;
      r_index     <= '0;
      for (int i = 0; i < NUM_WR_REGS; i++) r_regs[i] <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_hit) begin
            r_xferack <= 1'b1;
            r_index   <= w_index;
            r_state   <= ST_ACK;
            if (hba_rnw) begin
              r_dbus      <= w_rd_data;
              r_rd_strobe <= w_in_any_range;
            end else if (w_in_wr_range) begin
              for (int i = 0; i < NUM_WR_REGS; i++) begin
                if (w_index == REG_ADDR_WIDTH'(i)) r_regs[i] <= hba_dbus;
              end
              r_wr_strobe <= 1'b1;
            end
          end
        end
        ST_ACK: begin
          r_xferack   <= 1'b0;
          r_dbus      <= '0;
          r_wr_strobe <= 1'b0;
          r_rd_strobe <= 1'b0;
          r_state     <= ST_DESEL;
        end
        ST_DESEL: begin
          if (!hba_select) r_state <= ST_IDLE;
        end
        default: begin
          r_xferack   <= 1'b0;
          r_dbus      <= '0;
          r_wr_strobe <= 1'b0;
          r_rd_strobe <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  for (genvar g = 0; g < NUM_WR_REGS; g++) begin : g_reg_out
    assign reg_out[g*DBUS_WIDTH +: DBUS_WIDTH] = r_regs[g];
  end

  assign slave_xferack = r_xferack;
  assign slave_dbus    = r_dbus;
  assign reg_wr_strobe = r_wr_strobe;
  assign reg_rd_strobe = r_rd_strobe;
  assign reg_index     = r_index;

endmodule

// File: doc/hba_reg_bank.md
# hba_reg_bank

HBA bus slave (responder) with a parameterised register bank. It decodes transfers from the HBA master and arbiter whose peripheral address matches `PERIPH_ADDR`. It completes each transfer with a single-cycle `slave_xferack`, and exposes stored read/write registers and externally driven read-only registers to the peripheral core. Every peripheral in the design instantiates it as its bus front end.

## Interface
Parameters:
- `DBUS_WIDTH`, 8: data bus width.
- `PERIPH_ADDR_WIDTH`, 4: peripheral-select field width (upper bits of `hba_abus`).
- `REG_ADDR_WIDTH`, 8: register-index field width (lower bits of `hba_abus`).
- `ADDR_WIDTH`, `PERIPH_ADDR_WIDTH+REG_ADDR_WIDTH`: full address width.
- `PERIPH_ADDR`, 0: this peripheral's address; compared against `hba_abus[ADDR_WIDTH-1:REG_ADDR_WIDTH]`.
- `NUM_WR_REGS`, 4: stored R/W registers, occupying indices 0..`NUM_WR_REGS`-1.
- `NUM_RD_REGS`, 2: read-only registers, occupying indices `NUM_WR_REGS`..`NUM_WR_REGS+NUM_RD_REGS`-1.

Ports (one clock, `hba_clk`; reset `hba_reset` is asynchronous, active-high):
- `hba_clk` in 1: bus clock; all state on rising edge.
- `hba_reset` in 1: asynchronous active-high reset.
- `hba_select` in 1: transfer in progress (from master).
- `hba_rnw` in 1: 1 = read, 0 = write.
- `hba_abus` in `ADDR_WIDTH`: target address.
- `hba_dbus` in `DBUS_WIDTH`: write data from master.
- `slave_xferack` out 1: transfer complete, exactly one cycle.
- `slave_dbus` out `DBUS_WIDTH`: read data; zero whenever `slave_xferack`=0 (OR-combined bus).
- `reg_out` out `NUM_WR_REGS*DBUS_WIDTH`: stored registers; register i at bits [i*DBUS_WIDTH +: DBUS_WIDTH].
- `reg_in` in `NUM_RD_REGS*DBUS_WIDTH`: read-only register values; same packing, index offset `NUM_WR_REGS`.
- `reg_wr_strobe` out 1: one-cycle pulse on each accepted write.
- `reg_rd_strobe` out 1: one-cycle pulse on each accepted read.
- `reg_index` out `REG_ADDR_WIDTH`: register index of the last accepted transfer.

## Operation
- Hit condition: `hba_select`=1 and the peripheral field equals `PERIPH_ADDR`. Non-hits produce no output change.
- States:
  - IDLE: on a hit, perform the access, set `slave_xferack`<=1, `reg_index`<=index, go to ACK.
  - ACK: `slave_xferack`<=0, `slave_dbus`<=0, strobes<=0, go to DESEL.
  - DESEL: wait for `hba_select`=0, then go to IDLE.
  - Undefined encodings go to IDLE.
- Write (`hba_rnw`=0), index < `NUM_WR_REGS`: register <= `hba_dbus`, `reg_wr_strobe`<=1.
- Read (`hba_rnw`=1):
  - Index < `NUM_WR_REGS`: `slave_dbus` <= stored value.
  - Index in the read-only range: `slave_dbus` <= corresponding `reg_in` slice, sampled at the hit edge.
  - `reg_rd_strobe`<=1 in both cases.
- Out-of-range index (≥ `NUM_WR_REGS+NUM_RD_REGS`):
  - Still acked, so the bus never hangs.
  - Writes are discarded.
  - Reads return 0.
  - No strobe.
- Writes to a read-only index are discarded, acked, no strobe.
- `hba_dbus` is ignored on reads.
- Registers change only via the bus.
- Reset (asynchronous, any state, including mid-transfer):
  - State goes to IDLE.
  - `slave_xferack`, `slave_dbus`, `reg_out`, `reg_wr_strobe`, `reg_rd_strobe`, `reg_index` all go to 0.

## Timing
- Hit sampled at edge t: `slave_xferack`, `slave_dbus`, `reg_out` update, and strobe are visible after t, for one cycle.
- Latency is one cycle from select-with-address to ack.
- `slave_xferack` is never high on two consecutive cycles.
- At most one ack per select assertion, however long `hba_select` stays high; DESEL enforces this.
- Minimum transfer spacing: master drops select at t+2, slave returns to IDLE at t+3, and a new hit is accepted at the next edge where select is high.
- Address and data are sampled only at the hit edge; later changes while selected are ignored.
- `reg_wr_strobe` and the `reg_out` update become visible in the same cycle.

## Test plan
- **Write hit:** `PERIPH_ADDR`=3, write `hba_abus`=0x302, `hba_dbus`=0xA5.
  - Required: `slave_xferack` high one cycle after select, `reg_out[23:16]`=0xA5, `reg_wr_strobe` one cycle, `reg_index`=2, other registers unchanged.
- **Read-back and read-only:** read 0x302, then 0x305 with `reg_in[15:8]`=0x3C.
  - Required: `slave_dbus`=0xA5, then 0x3C, each only during its ack cycle; `reg_rd_strobe` pulses; `slave_dbus`=0 otherwise.
- **Miss and out-of-range:**
  - Select with `hba_abus`=0x202 gives no ack and no state change.
  - Write 0x3FF=0x11 is acked with no strobe and `reg_out` unchanged.
  - Read 0x3FF returns 0.
- **Held select:** hold `hba_select`=1 for 6 cycles on a write to 0x301.
  - Required: exactly one ack and one strobe; the next transfer is accepted only after select drops.
- **Async reset mid-transfer:** assert `hba_reset` off-edge during ACK.
  - Required: `slave_xferack`, `slave_dbus`, `reg_out`, strobes go to 0 immediately; after release, a new write to 0x300 is acked normally.
- **Back-to-back:** drive with the hba_master model issuing write 0x300=0x5A followed immediately by a read of 0x300.
  - Required: the read returns 0x5A, with no missed or duplicate ack.
